// File: rtl/fixed_point_pkg.sv
// ============================================================================
// Module   : fixed_point_pkg
// Brief    : Shared Q8.8 format constants and accumulator state encoding.
// Revision : 1.0
// ============================================================================
`default_nettype none

package fixed_point_pkg;

  localparam int DATA_W    = 16;
  localparam int FRAC_BITS = 8;

  localparam logic [DATA_W-1:0] SAT_MAX = 16'h7FFF;
  localparam logic [DATA_W-1:0] SAT_MIN = 16'h8000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/fixed_point_sat_adder.sv
// ============================================================================
// Module   : fixed_point_sat_adder
// Brief    : Combinational two's-complement adder clamping to the W-bit range.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fixed_point_sat_adder #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         sat_event
);

  localparam logic [W-1:0] MAX_VAL = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] MIN_VAL = {1'b1, {(W-1){1'b0}}};

  logic [W:0] full_sum;

  assign full_sum = {a[W-1], a} + {b[W-1], b};

  // The two top bits of the W+1 result disagree exactly when the sum left range.
  always_comb begin
    sat_event = full_sum[W] ^ full_sum[W-1];
    if (!sat_event) begin
      sum = full_sum[W-1:0];
    end else if (full_sum[W]) begin
      sum = MIN_VAL;
    end else begin
      sum = MAX_VAL;
    end
  end

endmodule

`default_nettype wire

// File: rtl/fixed_point_accumulator.sv
// ============================================================================
// Module   : fixed_point_accumulator
// Brief    : Sums a burst of multiplier products into one saturated result.
//            Define ACC_GUARD_EN to widen the accumulator by GUARD_BITS and
//            saturate only once at the end of the burst.
// Revision : 1.0
// ============================================================================
`default_nettype none

module fixed_point_accumulator
  import fixed_point_pkg::*;
#(
  parameter int DATA_W     = fixed_point_pkg::DATA_W,
  parameter int CNT_W      = 8,
  parameter int GUARD_BITS = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_product,
  input  logic              in_mult_ovf,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_ovf,
  output logic [CNT_W-1:0]  out_count
);

`ifdef ACC_GUARD_EN
  localparam bit GUARD_EN = 1'b1;
`else
  localparam bit GUARD_EN = 1'b0;
`endif
  localparam int ACC_W = DATA_W + (GUARD_EN ? GUARD_BITS : 0);

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]  sum_q, sum_d;
  logic               ovf_q, ovf_d;
  logic [CNT_W-1:0]   count_q, count_d;

  logic               accept;
  logic               cnt_full;
  logic [ACC_W-1:0]   first_acc;
  logic [ACC_W-1:0]   add_acc;
  logic               add_evt;
  logic [DATA_W-1:0]  add_final;
  logic               final_evt;

`ifdef ACC_GUARD_EN
  localparam logic [DATA_W-1:0] MAX_VAL = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_VAL = {1'b1, {(DATA_W-1){1'b0}}};

  logic [ACC_W-1:0] prod_ext;
  logic [ACC_W:0]   raw_sum;
  logic             in_range;

  // Wide adds wrap freely; only a wrap of the guarded register itself is flagged.
  assign prod_ext  = {{GUARD_BITS{in_product[DATA_W-1]}}, in_product};
  assign raw_sum   = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
  assign add_acc   = raw_sum[ACC_W-1:0];
  assign add_evt   = raw_sum[ACC_W] ^ raw_sum[ACC_W-1];
  assign in_range  = (&add_acc[ACC_W-1:DATA_W-1]) | ~(|add_acc[ACC_W-1:DATA_W-1]);
  assign add_final = in_range ? add_acc[DATA_W-1:0]
                              : (add_acc[ACC_W-1] ? MIN_VAL : MAX_VAL);
  assign final_evt = ~in_range;
  assign first_acc = prod_ext;
`else
  fixed_point_sat_adder #(
    .W (DATA_W)
  ) u_sat_adder (
    .a         (acc_q),
    .b         (in_product),
    .sum       (add_acc),
    .sat_event (add_evt)
  );

  assign add_final = add_acc;
  assign final_evt = 1'b0;
  assign first_acc = in_product;
`endif

  assign accept   = in_valid & in_ready;
  assign cnt_full = &count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
      count_q <= count_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (clear) begin
          acc_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
        end else if (accept) begin
          acc_d   = first_acc;
          ovf_d   = in_mult_ovf;
          count_d = CNT_W'(1);
          if (in_last) begin
            sum_d   = in_product;
            state_d = DONE;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (clear) begin
          acc_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = IDLE;
        end else if (accept) begin
          acc_d = add_acc;
          ovf_d = ovf_q | in_mult_ovf | add_evt | cnt_full;
          if (!cnt_full) begin
            count_d = count_q + 1'b1;
          end
          if (in_last) begin
            sum_d   = add_final;
            ovf_d   = ovf_q | in_mult_ovf | add_evt | cnt_full | final_evt;
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          acc_d   = '0;
          sum_d   = '0;
          ovf_d   = 1'b0;
          count_d = '0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    in_ready  = ~rst & (state_q != DONE) & ~clear;
    out_valid = (state_q == DONE);
    out_sum   = sum_q;
    out_ovf   = ovf_q;
    out_count = count_q;
  end

endmodule

`default_nettype wire

// File: tb/tb_fixed_point_accumulator.sv
// ============================================================================
// Module   : tb_fixed_point_accumulator
// Brief    : Directed checks of the burst accumulator, with a second CNT_W=2
//            instance sharing the inputs for the counter-limit case.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_fixed_point_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_product = 16'h0000;
  logic        in_mult_ovf = 1'b0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_ovf;
  logic [15:0] out_sum;
  logic [7:0]  out_count;

  logic        in_ready2, out_valid2, out_ovf2;
  logic [15:0] out_sum2;
  logic [1:0]  out_count2;

  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  fixed_point_accumulator #(.DATA_W(16), .CNT_W(8), .GUARD_BITS(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready),
    .in_product(in_product), .in_mult_ovf(in_mult_ovf), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
    .out_ovf(out_ovf), .out_count(out_count)
  );

  fixed_point_accumulator #(.DATA_W(16), .CNT_W(2), .GUARD_BITS(4)) dut_cnt2 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_ready(in_ready2),
    .in_product(in_product), .in_mult_ovf(in_mult_ovf), .in_last(in_last),
    .out_valid(out_valid2), .out_ready(out_ready), .out_sum(out_sum2),
    .out_ovf(out_ovf2), .out_count(out_count2)
  );

  task automatic send(input logic [15:0] p, input logic mo, input logic last);
    @(negedge clk);
    in_valid = 1'b1; in_product = p; in_mult_ovf = mo; in_last = last;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_mult_ovf = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    tests++; if ({out_sum, out_ovf, out_count} !== 25'd0) begin failed++; $display("FAIL reset_outputs: got sum %h ovf %b cnt %0d want 0", out_sum, out_ovf, out_count); end
    rst = 1'b0;
    #1;
    tests++; if (in_ready !== 1'b1) begin failed++; $display("FAIL idle_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    send(16'h0100, 1'b0, 1'b0);
    send(16'h0180, 1'b0, 1'b0);
    send(16'hFF00, 1'b0, 1'b1);
    tests++; if (out_valid !== 1'b0) begin failed++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    idle();
    tests++; if (out_valid !== 1'b1) begin failed++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    tests++; if (out_sum !== 16'h0180) begin failed++; $display("FAIL basic_sum: got %h want 0180", out_sum); end
    tests++; if (out_ovf !== 1'b0) begin failed++; $display("FAIL basic_ovf: got %b want 0", out_ovf); end
    tests++; if (out_count !== 8'd3) begin failed++; $display("FAIL basic_count: got %0d want 3", out_count); end
    tests++; if (in_ready !== 1'b0) begin failed++; $display("FAIL basic_done_ready: got %b want 0", in_ready); end
    drain();
    tests++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin failed++; $display("FAIL basic_drain: got valid %b ready %b want 0 1", out_valid, in_ready); end
  endtask

  task automatic test_pos_sat();
    logic [15:0] exp_sum;
    logic        exp_ovf;
    send(16'h7000, 1'b0, 1'b0);
    send(16'h7000, 1'b0, 1'b1);
    idle();
    tests++; if (out_sum !== 16'h7FFF || out_ovf !== 1'b1) begin failed++; $display("FAIL pos_sat: got %h ovf %b want 7fff ovf 1", out_sum, out_ovf); end
    drain();
`ifdef ACC_GUARD_EN
    exp_sum = 16'h7000; exp_ovf = 1'b0;
`else
    exp_sum = 16'h0FFF; exp_ovf = 1'b1;
`endif
    send(16'h7000, 1'b0, 1'b0);
    send(16'h7000, 1'b0, 1'b0);
    send(16'h9000, 1'b0, 1'b1);
    idle();
    tests++; if (out_sum !== exp_sum || out_ovf !== exp_ovf) begin failed++; $display("FAIL pos_sat_return: got %h ovf %b want %h ovf %b", out_sum, out_ovf, exp_sum, exp_ovf); end
    drain();
  endtask

  task automatic test_neg_sat();
    send(16'h8000, 1'b0, 1'b0);
    send(16'hFF00, 1'b0, 1'b1);
    idle();
    tests++; if (out_sum !== 16'h8000 || out_ovf !== 1'b1) begin failed++; $display("FAIL neg_sat: got %h ovf %b want 8000 ovf 1", out_sum, out_ovf); end
    drain();
    send(16'h0100, 1'b1, 1'b0);
    send(16'h0100, 1'b0, 1'b1);
    idle();
    tests++; if (out_sum !== 16'h0200 || out_ovf !== 1'b1) begin failed++; $display("FAIL mult_ovf_flag: got %h ovf %b want 0200 ovf 1", out_sum, out_ovf); end
    drain();
  endtask

  task automatic test_backpressure();
    send(16'h1234, 1'b0, 1'b1);
    @(negedge clk);
    in_product = 16'h5555;
    for (int i = 0; i < 5; i++) begin
      tests++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_sum !== 16'h1234 || out_count !== 8'd1 || out_ovf !== 1'b0) begin
        failed++;
        $display("FAIL backpressure_hold[%0d]: got valid %b ready %b sum %h cnt %0d ovf %b want 1 0 1234 1 0", i, out_valid, in_ready, out_sum, out_count, out_ovf);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    tests++; if (out_valid !== 1'b0 || out_count !== 8'd0) begin failed++; $display("FAIL backpressure_drain: got valid %b cnt %0d want 0 0", out_valid, out_count); end
    in_product = 16'h0040;
    idle();
    tests++; if (out_valid !== 1'b1 || out_sum !== 16'h0040 || out_count !== 8'd1) begin failed++; $display("FAIL after_drain_burst: got valid %b sum %h cnt %0d want 1 0040 1", out_valid, out_sum, out_count); end
    drain();
  endtask

  task automatic test_clear();
    send(16'h0100, 1'b0, 1'b0);
    send(16'h0200, 1'b0, 1'b0);
    @(negedge clk);
    in_product = 16'h0300; clear = 1'b1;
    #1;
    tests++; if (in_ready !== 1'b0 || out_count !== 8'd2) begin failed++; $display("FAIL clear_ready: got ready %b cnt %0d want 0 2", in_ready, out_count); end
    @(negedge clk);
    clear = 1'b0; in_valid = 1'b0;
    tests++; if (out_count !== 8'd0 || out_valid !== 1'b0) begin failed++; $display("FAIL clear_state: got cnt %0d valid %b want 0 0", out_count, out_valid); end
    send(16'h0010, 1'b0, 1'b1);
    idle();
    tests++; if (out_sum !== 16'h0010 || out_count !== 8'd1 || out_ovf !== 1'b0) begin failed++; $display("FAIL clear_next_burst: got %h cnt %0d ovf %b want 0010 1 0", out_sum, out_count, out_ovf); end
    drain();
  endtask

  task automatic test_async_reset();
    send(16'h7000, 1'b1, 1'b0);
    send(16'h0200, 1'b0, 1'b0);
    idle();
    tests++; if (out_count !== 8'd2 || out_ovf !== 1'b1) begin failed++; $display("FAIL pre_reset: got cnt %0d ovf %b want 2 1", out_count, out_ovf); end
    #2 rst = 1'b1;
    #1;
    tests++; if ({out_valid, in_ready, out_ovf, out_sum, out_count} !== 27'd0) begin failed++; $display("FAIL async_reset: got valid %b ready %b ovf %b sum %h cnt %0d want all 0", out_valid, in_ready, out_ovf, out_sum, out_count); end
    @(negedge clk);
    rst = 1'b0;
    send(16'h0003, 1'b0, 1'b1);
    idle();
    tests++; if (out_sum !== 16'h0003 || out_count !== 8'd1 || out_ovf !== 1'b0) begin failed++; $display("FAIL post_reset_burst: got %h cnt %0d ovf %b want 0003 1 0", out_sum, out_count, out_ovf); end
    drain();
  endtask

  task automatic test_count_limit();
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0001, 1'b0, 1'b0);
    send(16'h0001, 1'b0, 1'b1);
    idle();
    tests++; if (out_sum2 !== 16'h0004 || out_count2 !== 2'd3 || out_ovf2 !== 1'b1 || out_valid2 !== 1'b1) begin failed++; $display("FAIL count_limit: got sum %h cnt %0d ovf %b valid %b want 0004 3 1 1", out_sum2, out_count2, out_ovf2, out_valid2); end
    tests++; if (out_sum !== 16'h0004 || out_count !== 8'd4 || out_ovf !== 1'b0) begin failed++; $display("FAIL count_wide: got sum %h cnt %0d ovf %b want 0004 4 0", out_sum, out_count, out_ovf); end
    drain();
    tests++; if (in_ready2 !== 1'b1 || out_count2 !== 2'd0) begin failed++; $display("FAIL count_limit_drain: got ready %b cnt %0d want 1 0", in_ready2, out_count2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_pos_sat();
    test_neg_sat();
    test_backpressure();
    test_clear();
    test_async_reset();
    test_count_limit();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
